adder_result_buffer: RTL and testbench
======================================

// Module: adder_result_buffer
// PURPOSE
//  Downstream stage of the adder: captures every registered sum (c) qualified by the adder's valid.
//  Buffers sums in a small synchronous FIFO and presents them to a consumer over a valid/ready handshake.
//  The adder has no backpressure, so overflow drops the sum and raises a sticky flag.
// PARAMETERS
//  SUM_W   7   width of one sum word; matches the adder's c output
//  DEPTH   8   FIFO entries; power of two, >= 2
//  CNT_W   $clog2(DEPTH)+1   occupancy width (derived, localparam)
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       adder valid; a sum is offered this cycle
//  in_sum     in   SUM_W   adder c output
//  out_valid  out  1       head entry available
//  out_data   out  SUM_W   head entry, stable while out_valid && !out_ready
//  out_ready  in   1       consumer accepts the head this cycle
//  full       out  1       count == DEPTH
//  empty      out  1       count == 0
//  count      out  CNT_W   current occupancy
//  overflow   out  1       sticky: a sum was dropped since the last reset/clear
//  ovf_clr    in   1       clears overflow (synchronous)
// BEHAVIOUR
//  - Reset (sync, active-high): wr_ptr=rd_ptr=0, count=0, out_valid=0, out_data=0, full=0, empty=1,
//    overflow=0. FIFO contents are discarded. Reset mid-stream drops all held sums; no pop occurs that cycle.
//  - push = in_valid && (!full || pop); pop = out_valid && out_ready.
//  - Latency: a sum pushed at edge N into an empty buffer gives out_valid=1 after edge N.
//    No combinational fall-through from in_sum to out_data.
//  - out_data = mem[rd_ptr]. It is held constant while out_valid && !out_ready (no change under stall).
//  - Simultaneous push and pop: both take effect and count is unchanged. This includes full
//    (the push is accepted, not dropped) and count==1 (the new word becomes head next cycle).
//  - Drop: in_valid && full && !pop. The word is lost, state is unchanged, and overflow is set at the next edge.
//  - ovf_clr and a drop in the same cycle: overflow stays 1 (the set wins).
//  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. full/empty are derived from count.
//  - out_ready while empty is ignored. in_valid during reset is ignored.
// CONFIGURATION
//  RESULT_BUF_STATS_EN defined: adds outputs acc_cnt[15:0] and drop_cnt[15:0].
//   - acc_cnt increments on each push; drop_cnt increments on each drop.
//   - Both saturate at 16'hFFFF and clear on reset.
//  RESULT_BUF_STATS_EN undefined: those ports and counters are absent. Behaviour is otherwise identical.
// STRUCTURE
//  adder_pkg holds: SUM_W, DEPTH constants; typedef logic [SUM_W-1:0] sum_t; typedef for count.
//  One sub-module, result_fifo_mem: DEPTH x SUM_W register array with one write port and a
//  registered read. Pointer, count, handshake and flag logic live in adder_result_buffer.
//  Bench connects through an interface holding all ports, with the adder's c/valid driving in_sum/in_valid.
// TESTING
//  1 Reset: hold reset 2 cycles with in_valid=1 -> count=0, empty=1, out_valid=0, overflow=0.
//  2 Single pass: push 7'd12, out_ready=1 -> out_valid rises next cycle with out_data=12;
//    empty again one cycle after the pop.
//  3 Fill/order: push 3,5,9,...(8 words), out_ready=0 -> full=1, count=8;
//    then drain -> words emerge in push order.
//  4 Overflow: full, push 7'd99 with out_ready=0 -> 99 dropped, overflow=1, count=8;
//    ovf_clr -> overflow=0. ovf_clr together with a drop -> overflow stays 1.
//  5 Full push+pop: full, in_valid=1 with 7'd77, out_ready=1 -> count stays 8, no overflow,
//    77 emerges last. Also exercise pointer wrap over 20+ words.
//  6 Stall + reset: out_valid=1, out_ready=0 for 5 cycles -> out_data stable; assert reset
//    mid-stream -> all outputs return to reset values next cycle.
//    With RESULT_BUF_STATS_EN defined, check acc_cnt/drop_cnt after tests 3-5.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and types for the adder result buffer.
//  SUM_W : width of one sum word (matches the adder's c output)
//  DEPTH : FIFO entries, power of two, >= 2
//  CNT_W : occupancy width, wide enough to hold DEPTH itself
//  PTR_W : pointer width; pointers wrap naturally from DEPTH-1 to 0
package adder_pkg;
    localparam int SUM_W = 7;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [SUM_W-1:0] sum_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/adder_result_buffer_if.sv
// Bundle of every adder_result_buffer port, so a bench or parent can wire
// the adder's c/valid to in_sum/in_valid through one handle.
// Optional macro RESULT_BUF_STATS_EN adds the acc_cnt/drop_cnt signals.
interface adder_result_buffer_if (
    input logic clk
);
    logic              reset;
    logic              in_valid;
    adder_pkg::sum_t   in_sum;
    logic              out_valid;
    adder_pkg::sum_t   out_data;
    logic              out_ready;
    logic              full;
    logic              empty;
    adder_pkg::cnt_t   count;
    logic              overflow;
    logic              ovf_clr;
`ifdef RESULT_BUF_STATS_EN
    logic [15:0]       acc_cnt;
    logic [15:0]       drop_cnt;
`endif
endinterface

// File: rtl/result_fifo_mem.sv
// DEPTH x SUM_W storage for adder_result_buffer.
// One write port and a registered read port. The read register takes the
// write data when the address being written is the address read next, so a
// word written into an empty buffer appears on rd_data right after the same
// edge without any combinational path from wr_data to rd_data.
//  clk, reset : clock, synchronous active-high reset (clears rd_data only)
//  wr_en/wr_addr/wr_data : write port
//  rd_addr    : address to present after the next edge
//  rd_data    : registered read data
module result_fifo_mem
    import adder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic wr_en,
    input  ptr_t wr_addr,
    input  sum_t wr_data,
    input  ptr_t rd_addr,
    output sum_t rd_data
);
    sum_t mem_r [DEPTH];
    sum_t rd_data_r;

    // Storage array write port (contents are not reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read with write-through when reading the slot being written
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= sum_t'(0);
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_r <= wr_data;
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;
endmodule

// File: rtl/adder_result_buffer.sv
// Downstream stage of the adder: captures every valid sum into a small FIFO
// and presents it to a consumer over valid/ready. The adder cannot be
// stalled, so a sum arriving while full (and not popping) is dropped and
// raises the sticky overflow flag.
// Ports:
//  clk, reset            : clock, synchronous active-high reset
//  in_valid, in_sum      : sum offered by the adder this cycle
//  out_valid, out_data   : head entry, held stable while stalled
//  out_ready             : consumer accepts the head this cycle
//  full, empty, count    : occupancy status
//  overflow, ovf_clr     : sticky drop flag and its synchronous clear
// Optional macro RESULT_BUF_STATS_EN adds acc_cnt/drop_cnt saturating
// counters of accepted and dropped sums.
module adder_result_buffer
    import adder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  sum_t        in_sum,
    output logic        out_valid,
    output sum_t        out_data,
    input  logic        out_ready,
    output logic        full,
    output logic        empty,
    output cnt_t        count,
    output logic        overflow,
    input  logic        ovf_clr
`ifdef RESULT_BUF_STATS_EN
    ,
    output logic [15:0] acc_cnt,
    output logic [15:0] drop_cnt
`endif
);
    ptr_t wr_ptr_r;
    ptr_t rd_ptr_r;
    cnt_t count_r;
    logic out_valid_r;
    logic overflow_r;

    logic push_s;
    logic pop_s;
    logic drop_s;
    logic full_s;
    ptr_t rd_addr_next_s;
    cnt_t count_next_s;

    assign full_s = (count_r == cnt_t'(DEPTH));

    // Handshake decode: a pop frees a slot, so a push is accepted even when full
    always_comb begin
        pop_s  = out_valid_r && out_ready;
        push_s = in_valid && (!full_s || pop_s);
        drop_s = in_valid && full_s && !pop_s;
    end

    // Next read address and next occupancy
    always_comb begin
        rd_addr_next_s = rd_ptr_r;
        count_next_s   = count_r;
        if (pop_s) begin
            rd_addr_next_s = rd_ptr_r + ptr_t'(1);
        end else begin
            rd_addr_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + cnt_t'(1);
            2'b01:   count_next_s = count_r - cnt_t'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy, valid and sticky-overflow state
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= ptr_t'(0);
            rd_ptr_r    <= ptr_t'(0);
            count_r     <= cnt_t'(0);
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_t'(1);
            end
            rd_ptr_r    <= rd_addr_next_s;
            count_r     <= count_next_s;
            out_valid_r <= (count_next_s != cnt_t'(0));
            // A drop in the same cycle as ovf_clr keeps the flag set
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    result_fifo_mem u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_s && !reset),
        .wr_addr (wr_ptr_r),
        .wr_data (in_sum),
        .rd_addr (rd_addr_next_s),
        .rd_data (out_data)
    );

    assign out_valid = out_valid_r;
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = (count_r == cnt_t'(0));
    assign overflow  = overflow_r;

`ifdef RESULT_BUF_STATS_EN
    logic [15:0] acc_cnt_r;
    logic [15:0] drop_cnt_r;

    // Saturating counters of accepted and dropped sums
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt_r  <= 16'h0000;
            drop_cnt_r <= 16'h0000;
        end else begin
            if (push_s && (acc_cnt_r != 16'hFFFF)) begin
                acc_cnt_r <= acc_cnt_r + 16'h0001;
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end
        end
    end

    assign acc_cnt  = acc_cnt_r;
    assign drop_cnt = drop_cnt_r;
`endif
endmodule

// File: tb/tb_adder_result_buffer.sv
// Self-checking bench for adder_result_buffer. A queue-based model of the
// buffer (occupancy = queue size, head = front element) supplies every
// expected value. Inputs change 1 time unit after each rising edge, outputs
// are sampled at that same point, before the new inputs are applied.
module tb_adder_result_buffer;
    import adder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    adder_result_buffer_if bus (.clk(clk));

    adder_result_buffer dut (
        .clk       (bus.clk),
        .reset     (bus.reset),
        .in_valid  (bus.in_valid),
        .in_sum    (bus.in_sum),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_ready (bus.out_ready),
        .full      (bus.full),
        .empty     (bus.empty),
        .count     (bus.count),
        .overflow  (bus.overflow),
        .ovf_clr   (bus.ovf_clr)
`ifdef RESULT_BUF_STATS_EN
        ,
        .acc_cnt   (bus.acc_cnt),
        .drop_cnt  (bus.drop_cnt)
`endif
    );

    // Reference model state
    sum_t        mq[$];
    logic        m_ovf;
    int unsigned m_acc;
    int unsigned m_drop;

    int n_tests;
    int n_fail;

    task automatic drive(input logic v, input sum_t d, input logic r, input logic clr);
        bus.in_valid  = v;
        bus.in_sum    = d;
        bus.out_ready = r;
        bus.ovf_clr   = clr;
    endtask

    // Advance one clock and update the model from the inputs applied this cycle
    task automatic tick();
        bit mpop, mpush, mdrop;
        mpop  = (mq.size() != 0) && bus.out_ready;
        mpush = bus.in_valid && ((mq.size() < DEPTH) || mpop);
        mdrop = bus.in_valid && !mpush;
        @(posedge clk);
        if (bus.reset) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_acc  = 0;
            m_drop = 0;
        end else begin
            if (mpop) void'(mq.pop_front());
            if (mpush) mq.push_back(bus.in_sum);
            if (mdrop) m_ovf = 1'b1;
            else if (bus.ovf_clr) m_ovf = 1'b0;
            if (mpush && m_acc < 65535) m_acc++;
            if (mdrop && m_drop < 65535) m_drop++;
        end
        #1;
    endtask

    task automatic test_reset();
        bus.reset = 1'b1;
        drive(1'b1, sum_t'($urandom_range(127)), 1'b1, 1'b0);
        tick();
        tick();
        n_tests++;
        if (bus.count !== cnt_t'(0) || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status count=%0d empty=%0b full=%0b required 0/1/0", bus.count, bus.empty, bus.full);
        end
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.out_data !== sum_t'(0)) begin
            n_fail++;
            $display("FAIL reset_out out_valid=%0b overflow=%0b out_data=%0d required 0/0/0", bus.out_valid, bus.overflow, bus.out_data);
        end
        bus.reset = 1'b0;
        drive(1'b0, sum_t'(0), 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_single();
        drive(1'b1, 7'd12, 1'b1, 1'b0);
        tick();
        drive(1'b0, sum_t'(0), 1'b1, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 7'd12 || bus.count !== cnt_t'(1)) begin
            n_fail++;
            $display("FAIL single_latency out_valid=%0b out_data=%0d count=%0d required 1/12/1", bus.out_valid, bus.out_data, bus.count);
        end
        tick();
        n_tests++;
        if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty empty=%0b out_valid=%0b required 1/0", bus.empty, bus.out_valid);
        end
    endtask

    task automatic test_fill_order();
        sum_t w[8];
        w = '{7'd3, 7'd5, 7'd9, 7'd17, 7'd33, 7'd65, 7'd100, 7'd127};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, w[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, sum_t'(0), 1'b0, 1'b0);
        n_tests++;
        if (bus.full !== 1'b1 || bus.count !== cnt_t'(8) || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full full=%0b count=%0d overflow=%0b required 1/8/0", bus.full, bus.count, bus.overflow);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== w[i]) begin
                n_fail++;
                $display("FAIL fill_order[%0d] out_valid=%0b out_data=%0d required 1/%0d", i, bus.out_valid, bus.out_data, w[i]);
            end
            tick();
        end
        n_tests++;
        if (bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_drained empty=%0b required 1", bus.empty);
        end
    endtask

    task automatic test_overflow();
        sum_t w[8];
        for (int i = 0; i < 8; i++) begin
            w[i] = sum_t'($urandom_range(127));
            drive(1'b1, w[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 7'd99, 1'b0, 1'b0);
        tick();
        drive(1'b0, sum_t'(0), 1'b0, 1'b1);
        n_tests++;
        if (bus.overflow !== 1'b1 || bus.count !== cnt_t'(8) || bus.out_data !== w[0]) begin
            n_fail++;
            $display("FAIL ovf_drop overflow=%0b count=%0d head=%0d required 1/8/%0d", bus.overflow, bus.count, bus.out_data, w[0]);
        end
        tick();
        n_tests++;
        if (bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear overflow=%0b required 0", bus.overflow);
        end
        drive(1'b1, 7'd55, 1'b0, 1'b1);
        tick();
        drive(1'b0, sum_t'(0), 1'b1, 1'b0);
        n_tests++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins overflow=%0b required 1", bus.overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (bus.out_data !== w[i]) begin
                n_fail++;
                $display("FAIL ovf_order[%0d] out_data=%0d required %0d", i, bus.out_data, w[i]);
            end
            tick();
        end
`ifdef RESULT_BUF_STATS_EN
        n_tests++;
        if (bus.acc_cnt !== 16'(m_acc) || bus.drop_cnt !== 16'(m_drop)) begin
            n_fail++;
            $display("FAIL stats acc=%0d drop=%0d required %0d/%0d", bus.acc_cnt, bus.drop_cnt, m_acc, m_drop);
        end
`endif
    endtask

    task automatic test_full_push_pop();
        sum_t w[8];
        drive(1'b0, sum_t'(0), 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            w[i] = sum_t'($urandom_range(127));
            drive(1'b1, w[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 7'd77, 1'b1, 1'b0);
        tick();
        drive(1'b0, sum_t'(0), 1'b1, 1'b0);
        n_tests++;
        if (bus.count !== cnt_t'(8) || bus.overflow !== 1'b0 || bus.out_data !== w[1]) begin
            n_fail++;
            $display("FAIL fullpp count=%0d overflow=%0b head=%0d required 8/0/%0d", bus.count, bus.overflow, bus.out_data, w[1]);
        end
        for (int i = 1; i < 9; i++) begin
            n_tests++;
            if (bus.out_data !== ((i == 8) ? 7'd77 : w[i])) begin
                n_fail++;
                $display("FAIL fullpp_order[%0d] out_data=%0d required %0d", i, bus.out_data, (i == 8) ? 7'd77 : w[i]);
            end
            tick();
        end
    endtask

    // Random traffic against the model; long enough to wrap the pointers several times
    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            bus.reset = ($urandom_range(99) == 0);
            drive(1'($urandom_range(3) != 0), sum_t'($urandom_range(127)),
                  1'($urandom_range(2) == 0), 1'($urandom_range(15) == 0));
            tick();
            n_tests++;
            if (bus.count !== cnt_t'(mq.size()) || bus.out_valid !== (mq.size() != 0) ||
                bus.overflow !== m_ovf || bus.full !== (mq.size() == DEPTH) ||
                (mq.size() != 0 && bus.out_data !== mq[0])) begin
                n_fail++;
                $display("FAIL random[%0d] count=%0d valid=%0b ovf=%0b data=%0d required %0d/%0b/%0b/%0d",
                         c, bus.count, bus.out_valid, bus.overflow, bus.out_data,
                         mq.size(), mq.size() != 0, m_ovf, (mq.size() != 0) ? mq[0] : sum_t'(0));
            end
        end
        bus.reset = 1'b0;
    endtask

    task automatic test_stall_reset();
        sum_t head;
        bus.reset = 1'b1;
        drive(1'b0, sum_t'(0), 1'b0, 1'b0);
        tick();
        bus.reset = 1'b0;
        head = sum_t'($urandom_range(127));
        drive(1'b1, head, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, sum_t'($urandom_range(127)), 1'b0, 1'b0);
            tick();
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== head) begin
                n_fail++;
                $display("FAIL stall[%0d] out_valid=%0b out_data=%0d required 1/%0d", i, bus.out_valid, bus.out_data, head);
            end
        end
        bus.reset = 1'b1;
        drive(1'b1, sum_t'($urandom_range(127)), 1'b1, 1'b0);
        tick();
        n_tests++;
        if (bus.count !== cnt_t'(0) || bus.empty !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_data !== sum_t'(0) || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset count=%0d empty=%0b valid=%0b data=%0d full=%0b ovf=%0b required 0/1/0/0/0/0",
                     bus.count, bus.empty, bus.out_valid, bus.out_data, bus.full, bus.overflow);
        end
`ifdef RESULT_BUF_STATS_EN
        n_tests++;
        if (bus.acc_cnt !== 16'h0000 || bus.drop_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL stats_reset acc=%0d drop=%0d required 0/0", bus.acc_cnt, bus.drop_cnt);
        end
`endif
        bus.reset = 1'b0;
        drive(1'b0, sum_t'(0), 1'b0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_ovf   = 1'b0;
        m_acc   = 0;
        m_drop  = 0;
        bus.reset = 1'b1;
        drive(1'b0, sum_t'(0), 1'b0, 1'b0);
        #1;
        test_reset();
        test_single();
        test_fill_order();
        test_overflow();
        test_full_push_pop();
        test_random(400);
        test_stall_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
